// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI load sequencer: FSM encoding, default widths, write-flag position.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_seq_pkg;

    localparam int SEQ_DWIDTH   = 16;
    localparam int SEQ_NUM_SEG  = 8;
    localparam int SEQ_LEN_W    = 12;
    localparam int SEQ_SRC_AW   = 12;
    localparam int SEQ_STRIDE_W = 4;
    localparam int SEQ_TMO_CYC  = 4096;

    // Bit of the SPI address word that marks a write transfer.
    localparam int SEQ_WR_BIT   = SEQ_DWIDTH - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEG_LD,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_NEXT,
        ST_FIN
    } seq_state_e;

endpackage

// File: rtl/spi_load_sequencer_if.sv
// Parallel-port bundle between the load sequencer (master modport) and the SPI master core (slave modport).
// Latency: n/a (wiring only).
// Backpressure: spi_busy from the SPI master holds off spi_start.
interface spi_load_sequencer_if
    import spi_seq_pkg::*;
#(
    parameter int DWIDTH = SEQ_DWIDTH
) ();
    logic [DWIDTH-1:0] spi_addr;
    logic [DWIDTH-1:0] spi_wdata;
    logic              spi_start;
    logic [15:0]       spi_nod;
    logic              spi_busy;
    logic              spi_done;
    logic [DWIDTH-1:0] spi_rdata;

    modport master (
        output spi_addr, spi_wdata, spi_start, spi_nod,
        input  spi_busy, spi_done, spi_rdata
    );

    modport slave (
        input  spi_addr, spi_wdata, spi_start, spi_nod,
        output spi_busy, spi_done, spi_rdata
    );
endinterface

// File: rtl/spi_seq_table.sv
// Segment table: NUM_SEG entries of {wr, base, len, stride}, written from config, read by the sequencer.
// Latency: write lands on the next clk edge; read is combinational.
// Backpressure: none; the caller gates writes.
module spi_seq_table
    import spi_seq_pkg::*;
#(
    parameter int NUM_SEG  = SEQ_NUM_SEG,
    parameter int AW       = SEQ_DWIDTH - 1,
    parameter int LEN_W    = SEQ_LEN_W,
    parameter int STRIDE_W = SEQ_STRIDE_W,
    parameter int IDX_W    = $clog2(NUM_SEG)
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [IDX_W-1:0]    widx_i,
    input  logic                wr_i,
    input  logic [AW-1:0]       base_i,
    input  logic [LEN_W-1:0]    len_i,
    input  logic [STRIDE_W-1:0] stride_i,
    input  logic [IDX_W-1:0]    ridx_i,
    output logic                wr_o,
    output logic [AW-1:0]       base_o,
    output logic [LEN_W-1:0]    len_o,
    output logic [STRIDE_W-1:0] stride_o
);
    logic                wr_q     [NUM_SEG];
    logic [AW-1:0]       base_q   [NUM_SEG];
    logic [LEN_W-1:0]    len_q    [NUM_SEG];
    logic [STRIDE_W-1:0] stride_q [NUM_SEG];

    // Entry write; contents intentionally survive reset so a table can be reused after a reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            wr_q[widx_i]     <= wr_i;
            base_q[widx_i]   <= base_i;
            len_q[widx_i]    <= len_i;
            stride_q[widx_i] <= stride_i;
        end
    end

    assign wr_o     = wr_q[ridx_i];
    assign base_o   = base_q[ridx_i];
    assign len_o    = len_q[ridx_i];
    assign stride_o = stride_q[ridx_i];
endmodule

// File: rtl/spi_load_sequencer.sv
// Walks the segment table and drives the SPI master parallel port; write bytes come from a source memory.
// Latency: spi_done -> next spi_start is 3 clk for writes, 2 clk for reads (more across segments).
// Backpressure: spi_busy holds ISSUE; abort stops after the in-flight transfer. Optional: SEQ_TIMEOUT_EN.
module spi_load_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DWIDTH   = SEQ_DWIDTH,
    parameter int NUM_SEG  = SEQ_NUM_SEG,
    parameter int LEN_W    = SEQ_LEN_W,
    parameter int SRC_AW   = SEQ_SRC_AW,
    parameter int STRIDE_W = SEQ_STRIDE_W,
    parameter int TMO_CYC  = SEQ_TMO_CYC
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_SEG)-1:0]   cfg_idx,
    input  logic                         cfg_wr,
    input  logic [DWIDTH-2:0]            cfg_base,
    input  logic [LEN_W-1:0]             cfg_len,
    input  logic [STRIDE_W-1:0]          cfg_stride,
    input  logic [$clog2(NUM_SEG):0]     cfg_nseg,
    input  logic                         go,
    input  logic                         abort,
    output logic [SRC_AW-1:0]            src_addr,
    input  logic [7:0]                   src_data,
    spi_load_sequencer_if.master         spi,
    output logic                         rd_valid,
    output logic [DWIDTH-1:0]            rd_data,
    output logic [DWIDTH-2:0]            rd_addr,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);
    localparam int AW    = DWIDTH - 1;
    localparam int SEG_W = $clog2(NUM_SEG);

    seq_state_e           state_q;
    logic [SEG_W:0]       seg_q, nseg_q;
    logic [LEN_W-1:0]     len_q, idx_q;
    logic [STRIDE_W-1:0]  stride_q;
    logic                 wr_q, abort_q;
    logic [AW-1:0]        addr_q;
    logic [SRC_AW-1:0]    ptr_q;
    logic                 spi_start_q, rd_valid_q, busy_q, done_q;
    logic [DWIDTH-1:0]    spi_addr_q, spi_wdata_q, rd_data_q;
    logic [15:0]          spi_nod_q;
    logic [AW-1:0]        rd_addr_q;

    logic                 tbl_wr;
    logic [AW-1:0]        tbl_base;
    logic [LEN_W-1:0]     tbl_len;
    logic [STRIDE_W-1:0]  tbl_stride;
    logic                 abort_seen;

    assign abort_seen = abort_q | abort;

    spi_seq_table #(
        .NUM_SEG  (NUM_SEG),
        .AW       (AW),
        .LEN_W    (LEN_W),
        .STRIDE_W (STRIDE_W)
    ) u_table (
        .clk      (clk),
        .we_i     (cfg_we && (state_q == ST_IDLE)),
        .widx_i   (cfg_idx),
        .wr_i     (cfg_wr),
        .base_i   (cfg_base),
        .len_i    (cfg_len),
        .stride_i (cfg_stride),
        .ridx_i   (seg_q[SEG_W-1:0]),
        .wr_o     (tbl_wr),
        .base_o   (tbl_base),
        .len_o    (tbl_len),
        .stride_o (tbl_stride)
    );

`ifdef SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TMO_CYC != 0);
`endif

    // Sequencer FSM; every output is a register written here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            seg_q       <= '0;
            nseg_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            stride_q    <= '0;
            wr_q        <= 1'b0;
            abort_q     <= 1'b0;
            addr_q      <= '0;
            ptr_q       <= '0;
            spi_start_q <= 1'b0;
            spi_addr_q  <= '0;
            spi_wdata_q <= '0;
            spi_nod_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_addr_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            spi_start_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            // Abort is only meaningful once a sequence is running; it is cleared by the next go.
            if (state_q != ST_IDLE && abort) begin
                abort_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        seg_q   <= '0;
                        nseg_q  <= cfg_nseg;
                        abort_q <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                        state_q <= (cfg_nseg == '0) ? ST_FIN : ST_SEG_LD;
                    end
                end
                ST_SEG_LD: begin
                    wr_q      <= tbl_wr;
                    len_q     <= tbl_len;
                    stride_q  <= tbl_stride;
                    addr_q    <= tbl_base;
                    idx_q     <= '0;
                    spi_nod_q <= 16'(tbl_len);
                    if (tbl_len == '0) begin
                        state_q <= ST_NEXT;
                    end else begin
                        state_q <= tbl_wr ? ST_FETCH : ST_ISSUE;
                    end
                end
                ST_FETCH: begin
                    // src_addr already shows ptr; the byte arrives next cycle.
                    state_q <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (!spi.spi_busy) begin
                        spi_start_q <= 1'b1;
                        spi_addr_q  <= {wr_q, addr_q};
                        spi_wdata_q <= wr_q ? {{(DWIDTH-8){1'b0}}, src_data} : '0;
`ifdef SEQ_TIMEOUT_EN
                        tmo_q       <= '0;
`endif
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (spi.spi_done) begin
                        if (wr_q) begin
                            ptr_q <= ptr_q + SRC_AW'(1);
                        end else begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= spi.spi_rdata;
                            rd_addr_q  <= addr_q;
                        end
                        idx_q  <= idx_q + LEN_W'(1);
                        addr_q <= addr_q + AW'(stride_q);
                        if (idx_q == len_q - LEN_W'(1) || abort_seen) begin
                            state_q <= ST_NEXT;
                        end else begin
                            state_q <= wr_q ? ST_FETCH : ST_ISSUE;
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
                        err_q   <= 1'b1;
                        abort_q <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
`endif
                end
                ST_NEXT: begin
                    seg_q <= seg_q + (SEG_W+1)'(1);
                    if (seg_q == nseg_q - (SEG_W+1)'(1) || abort_seen) begin
                        state_q <= ST_FIN;
                    end else begin
                        state_q <= ST_SEG_LD;
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign src_addr      = ptr_q;
    assign spi.spi_start = spi_start_q;
    assign spi.spi_addr  = spi_addr_q;
    assign spi.spi_wdata = spi_wdata_q;
    assign spi.spi_nod   = spi_nod_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign rd_addr       = rd_addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
`ifdef SEQ_TIMEOUT_EN
    assign err           = err_q;
`else
    assign err           = 1'b0;
`endif
endmodule

// File: tb/tb_spi_load_sequencer.sv
// Directed bench for spi_load_sequencer with a behavioural SPI master and source byte memory.
// Expected transfers/read words are queued at stimulus time and popped by a negedge monitor.
// Build with SEQ_TIMEOUT_EN defined to also exercise the watchdog.
module tb_spi_load_sequencer;
    import spi_seq_pkg::*;

    localparam int DW     = 16;
    localparam int STW    = 6;      // wide enough for the stride-32 segment
    localparam int TB_TMO = 4096;

    logic        clk;
    logic        reset;
    logic        cfg_we, cfg_wr, go, abort;
    logic [2:0]  cfg_idx;
    logic [14:0] cfg_base;
    logic [11:0] cfg_len;
    logic [STW-1:0] cfg_stride;
    logic [3:0]  cfg_nseg;
    logic [11:0] src_addr;
    logic [7:0]  src_data;
    logic        rd_valid, busy, done, err;
    logic [15:0] rd_data;
    logic [14:0] rd_addr;

    spi_load_sequencer_if #(.DWIDTH(DW)) spi ();

    spi_load_sequencer #(
        .DWIDTH(DW), .NUM_SEG(8), .LEN_W(12), .SRC_AW(12), .STRIDE_W(STW), .TMO_CYC(TB_TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_wr(cfg_wr), .cfg_base(cfg_base),
        .cfg_len(cfg_len), .cfg_stride(cfg_stride), .cfg_nseg(cfg_nseg),
        .go(go), .abort(abort),
        .src_addr(src_addr), .src_data(src_data),
        .spi(spi),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_addr(rd_addr),
        .busy(busy), .done(done), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0, n_fail = 0;
    int n_start = 0, done_cnt = 0, cyc = 0, last_done_cyc = 0;
    logic [47:0] exp_x[$];     // {spi_addr, spi_wdata, spi_nod}
    logic [30:0] exp_rd[$];    // {rd_addr, rd_data}
    int gap_q[$];              // cycles from previous spi_done to each spi_start
    logic [7:0] mem [4096];
    int m_lat, m_hold;
    bit m_hang;
    logic [15:0] m_rdata;
    int exp_ptr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [47:0] xf(input logic [15:0] a, input logic [15:0] d, input logic [15:0] n);
        return {a, d, n};
    endfunction

    // Synchronous source memory: data for the address seen in one cycle appears the next.
    initial begin
        logic [11:0] a;
        src_data = 8'h00;
        forever begin
            @(negedge clk);
            a = src_addr;
            @(posedge clk);
            #1;
            src_data = mem[a];
        end
    end

    // Behavioural SPI master: busy after start, done after m_lat cycles, optional post-done busy hold.
    initial begin
        spi.spi_busy  = 1'b0;
        spi.spi_done  = 1'b0;
        spi.spi_rdata = '0;
        forever begin
            @(negedge clk);
            if (spi.spi_start && !m_hang) begin
                tick();
                spi.spi_busy = 1'b1;
                repeat (m_lat - 1) tick();
                tick();
                spi.spi_done  = 1'b1;
                spi.spi_rdata = m_rdata;
                if (m_hold == 0) spi.spi_busy = 1'b0;
                tick();
                spi.spi_done = 1'b0;
                if (m_hold > 0) begin
                    repeat (m_hold - 1) tick();
                    spi.spi_busy = 1'b0;
                    m_hold = 0;
                end
            end
        end
    end

    // Monitor/scoreboard.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (spi.spi_start) begin
            n_start++;
            gap_q.push_back(cyc - last_done_cyc);
            if (exp_x.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_start: got addr 0x%0h, expected no transfer", spi.spi_addr);
            end else begin
                check("xfer", xf(spi.spi_addr, spi.spi_wdata, spi.spi_nod), exp_x.pop_front());
            end
        end
        if (rd_valid) begin
            if (exp_rd.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rd: got 0x%0h, expected no read word", rd_data);
            end else begin
                check("rd_word", {rd_addr, rd_data}, exp_rd.pop_front());
            end
        end
        if (spi.spi_done) last_done_cyc = cyc;
        if (done) done_cnt++;
    end

    task automatic cfg_entry(input int idx, input bit wr, input logic [14:0] base,
                             input int len, input int stride);
        cfg_idx    = 3'(idx);
        cfg_wr     = wr;
        cfg_base   = base;
        cfg_len    = 12'(len);
        cfg_stride = STW'(stride);
        cfg_we     = 1'b1;
        tick();
        cfg_we     = 1'b0;
    endtask

    task automatic start_seq(input int nseg);
        cfg_nseg = 4'(nseg);
        gap_q.delete();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int d0 = done_cnt;
        for (int k = 0; k < limit && done_cnt == d0; k++) tick();
        check(name, (done_cnt != d0), 1);
        check({name, "_drained"}, exp_x.size(), 0);
    endtask

    task automatic wait_starts(input int target, input int limit);
        for (int k = 0; k < limit && n_start < target; k++) tick();
        check("start_reached", (n_start >= target), 1);
    endtask

    task automatic push_writes(input logic [14:0] base, input int stride, input int len, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            exp_x.push_back(xf({1'b1, 15'(base + 15'(i * stride))}, {8'h00, mem[exp_ptr]}, 16'(len)));
            exp_ptr = (exp_ptr + 1) % 4096;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'((i * 37 + 11) & 8'hFF);
        reset = 1'b1; cfg_we = 0; cfg_wr = 0; cfg_idx = 0; cfg_base = 0; cfg_len = 0;
        cfg_stride = 0; cfg_nseg = 0; go = 0; abort = 0;
        m_lat = 1; m_hold = 0; m_hang = 0; m_rdata = 16'h002C; exp_ptr = 0;
        repeat (3) tick();
        check("reset_outputs", {spi.spi_start, busy, done, rd_valid, err, spi.spi_nod,
                                spi.spi_addr, spi.spi_wdata}, 0);
        check("reset_ptr", src_addr, 0);
        reset = 1'b0;
        tick();

        // 1: one write segment, 28 transfers, stride 32; a stray go mid-run is ignored.
        cfg_entry(0, 1, 15'h0000, 28, 32);
        push_writes(15'h0000, 32, 28, 28);
        start_seq(1);
        check("busy_after_go", busy, 1);
        wait_starts(5, 200);
        go = 1'b1; tick(); go = 1'b0;
        wait_done("t1_done", 400);
        check("t1_busy_low", busy, 0);
        check("t1_ptr", src_addr, 28);
        check("t1_write_gap", gap_q[1], 3);

        // Reset clears the source pointer.
        reset = 1'b1; tick(); tick();
        check("reset_clears_ptr", src_addr, 0);
        reset = 1'b0; tick();
        exp_ptr = 0;

        // 2: write len 3, then read 0x4001 len 1 returning 0x002C.
        cfg_entry(0, 1, 15'h0100, 3, 1);
        cfg_entry(1, 0, 15'h4001, 1, 1);
        push_writes(15'h0100, 1, 3, 3);
        exp_x.push_back(xf(16'h4001, 16'h0000, 16'd1));
        exp_rd.push_back({15'h4001, 16'h002C});
        start_seq(2);
        wait_done("t2_done", 200);
        check("t2_ptr", src_addr, 3);
        check("t2_rd_drained", exp_rd.size(), 0);

        // 3: read len 2, empty segment, write len 2 -> exactly 4 starts.
        cfg_entry(0, 0, 15'h0010, 2, 2);
        cfg_entry(1, 1, 15'h0300, 0, 1);
        cfg_entry(2, 1, 15'h0200, 2, 3);
        exp_x.push_back(xf(16'h0010, 16'h0000, 16'd2));
        exp_x.push_back(xf(16'h0012, 16'h0000, 16'd2));
        exp_rd.push_back({15'h0010, 16'h002C});
        exp_rd.push_back({15'h0012, 16'h002C});
        push_writes(15'h0200, 3, 2, 2);
        s0 = n_start;
        start_seq(3);
        wait_done("t3_done", 200);
        check("t3_start_count", n_start - s0, 4);
        check("t3_read_gap", gap_q[1], 2);
        check("t3_ptr", src_addr, 5);

        // 4: address wrap 0x7FFE..0x0001 with busy held 5 cycles after the first done.
        cfg_entry(0, 1, 15'h7FFE, 4, 1);
        for (int i = 0; i < 4; i++) begin
            exp_x.push_back(xf({1'b1, 15'(15'h7FFE + 15'(i))}, {8'h00, mem[exp_ptr]}, 16'd4));
            exp_ptr++;
        end
        m_hold = 5;
        s0 = n_start;
        start_seq(1);
        wait_done("t4_done", 200);
        check("t4_start_count", n_start - s0, 4);
        check("t4_busy_stall_gap", gap_q[1], 6);
        check("t4_normal_gap", gap_q[2], 3);

        // Zero active segments: straight to done, no transfer.
        s0 = n_start;
        start_seq(0);
        wait_done("nseg0_done", 20);
        check("nseg0_no_start", n_start - s0, 0);

        // 5: abort during transfer 2 of 10; config writes while busy are dropped.
        cfg_entry(0, 1, 15'h0000, 10, 1);
        m_lat = 4;
        push_writes(15'h0000, 1, 10, 2);
        s0 = n_start;
        start_seq(1);
        cfg_entry(0, 1, 15'h0555, 10, 1);
        wait_starts(s0 + 2, 100);
        abort = 1'b1; tick(); abort = 1'b0;
        wait_done("t5_abort_done", 100);
        check("t5_start_count", n_start - s0, 2);
        check("t5_ptr", src_addr, 11);

        // Reset mid-WAIT: sequencer idles and ignores the master's late done.
        push_writes(15'h0000, 1, 10, 1);
        s0 = n_start;
        start_seq(1);
        wait_starts(s0 + 1, 50);
        tick();
        reset = 1'b1; tick();
        check("rst_wait_idle", {spi.spi_start, busy}, 0);
        reset = 1'b0;
        s0 = done_cnt;
        repeat (12) tick();
        check("rst_no_restart", {busy, 12'(src_addr), 8'(done_cnt - s0)}, 0);
        m_lat = 1;
        exp_ptr = 0;

`ifdef SEQ_TIMEOUT_EN
        // 6: master never completes -> watchdog sets err and ends the sequence.
        cfg_entry(0, 1, 15'h0000, 2, 1);
        push_writes(15'h0000, 1, 2, 1);
        m_hang = 1;
        s0 = n_start;
        start_seq(1);
        wait_done("t6_tmo_done", TB_TMO + 100);
        check("t6_err_set", err, 1);
        check("t6_start_count", n_start - s0, 1);
        m_hang = 0;
        start_seq(0);
        check("t6_err_cleared", err, 0);
        wait_done("t6_clear_done", 20);
`endif

        check("final_x_queue", exp_x.size(), 0);
        check("final_rd_queue", exp_rd.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
